serial_frame_rx: RTL and testbench

//  Receive end of the team's single-wire serial link: one bit per clk, LSB first.

---
 rtl/serial_frame_rx_if.sv | 41 ++++
 rtl/serial_frame_rx.sv | 147 ++++++++++++++
 tb/tb_serial_frame_rx.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_rx_if.sv
// Serial receiver bundle: serial line and ack in, parallel word plus status out.
`default_nettype none

interface serial_frame_rx_if #(
  parameter int WIDTH = 8
);
  logic             din;
  logic             dout_ack;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             parity_err;
  logic             frame_err;
  logic             overrun;
  logic             busy;

  // Receiver side: samples the line, presents the word.
  modport master (
    input  din,
    input  dout_ack,
    output dout,
    output dout_valid,
    output parity_err,
    output frame_err,
    output overrun,
    output busy
  );

  // Line driver / word consumer side.
  modport slave (
    output din,
    output dout_ack,
    input  dout,
    input  dout_valid,
    input  parity_err,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

`default_nettype wire

// File: rtl/serial_frame_rx.sv
// ---------------------------------------------------------------------------
// serial_frame_rx : one-bit-per-clock framed serial receiver (LSB first)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_frame_rx #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  serial_frame_rx_if.master  bus
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_PARITY = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic             par_bit;

  logic [WIDTH-1:0] word;
  logic             word_valid;
  logic             word_perr;
  logic             ferr;
  logic             ovr;

  logic             good_stop;
  logic             bad_stop;
  logic             take;
  logic             word_parity;

  assign take        = bus.dout_ack & word_valid;
  assign word_parity = PARITY_EN ? (^shreg ^ par_bit) : 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    good_stop  = 1'b0;
    bad_stop   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!bus.din) state_next = S_DATA;
      end
      S_DATA: begin
        if (count == LAST) state_next = PARITY_EN ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        state_next = S_STOP;
      end
      S_STOP: begin
        if (bus.din) begin
          good_stop  = 1'b1;
          state_next = S_IDLE;
        end else begin
          bad_stop   = 1'b1;
          state_next = S_BREAK;
        end
      end
      // A line held low after a bad stop must return high before a new start is honoured.
      S_BREAK: begin
        if (bus.din) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      count   <= '0;
      par_bit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          count <= '0;
        end
        S_DATA: begin
          shreg[count] <= bus.din;
          count        <= count + CW'(1);
        end
        S_PARITY: begin
          par_bit <= bus.din;
        end
        default: begin
        end
      endcase
    end
  end

  // Ack and a fresh word on the same edge: the new word wins and overrun is cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word       <= '0;
      word_valid <= 1'b0;
      word_perr  <= 1'b0;
      ferr       <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      ferr <= bad_stop;
      if (good_stop) begin
        word      <= shreg;
        word_perr <= word_parity;
      end
      if (good_stop) begin
        word_valid <= 1'b1;
      end else if (take) begin
        word_valid <= 1'b0;
      end
      if (take) begin
        ovr <= 1'b0;
      end else if (good_stop && word_valid) begin
        ovr <= 1'b1;
      end
    end
  end

  assign bus.dout       = word;
  assign bus.dout_valid = word_valid;
  assign bus.parity_err = word_perr;
  assign bus.frame_err  = ferr;
  assign bus.overrun    = ovr;
  assign bus.busy       = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: parity-enabled and parity-less instances.
`default_nettype none
`timescale 1ns/1ps

module tb_serial_frame_rx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_frame_rx_if #(.WIDTH(8)) bus_p ();
  serial_frame_rx_if #(.WIDTH(8)) bus_n ();

  serial_frame_rx #(.WIDTH(8), .PARITY_EN(1'b1)) dut_p (.clk(clk), .rst(rst), .bus(bus_p.master));
  serial_frame_rx #(.WIDTH(8), .PARITY_EN(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n.master));

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ovr;
  } exp_t;

  exp_t q_p[$];
  exp_t q_n[$];
  int   tests = 0;
  int   fails = 0;
  int   fe_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_p(input logic b);
    bus_p.din = b;
    tick();
  endtask

  task automatic ack_p();
    bus_p.dout_ack = 1'b1;
    tick();
    bus_p.dout_ack = 1'b0;
  endtask

  // Good frame on the parity instance; expected word/status pushed before the stimulus.
  task automatic frame_p(input logic [7:0] d, input logic par, input logic ack_on_stop,
                         input logic [7:0] exp_d, input logic exp_perr, input logic exp_ovr);
    exp_t e;
    e.data = exp_d;
    e.perr = exp_perr;
    e.ovr  = exp_ovr;
    q_p.push_back(e);
    bit_p(1'b0);
    for (int i = 0; i < 8; i++) bit_p(d[i]);
    bit_p(par);
    bus_p.dout_ack = ack_on_stop;
    bit_p(1'b1);
    bus_p.dout_ack = 1'b0;
  endtask

  // Monitor for the parity instance: a new presentation is a rising valid or a changed word.
  logic       pv_p = 1'b0;
  logic [7:0] pd_p = 8'h00;
  logic       pp_p = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && bus_p.dout_valid === 1'b1 &&
        (!pv_p || bus_p.dout != pd_p || bus_p.parity_err != pp_p)) begin
      if (q_p.size() == 0) begin
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL mon_p unexpected word: got %0h expected none", bus_p.dout);
      end else begin
        e = q_p.pop_front();
        check("mon_p dout", 32'(bus_p.dout), 32'(e.data));
        check("mon_p parity_err", 32'(bus_p.parity_err), 32'(e.perr));
        check("mon_p overrun", 32'(bus_p.overrun), 32'(e.ovr));
      end
    end
    if (bus_p.frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    pv_p <= bus_p.dout_valid;
    pd_p <= bus_p.dout;
    pp_p <= bus_p.parity_err;
  end

  logic       pv_n = 1'b0;
  logic [7:0] pd_n = 8'h00;
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && bus_n.dout_valid === 1'b1 && (!pv_n || bus_n.dout != pd_n)) begin
      if (q_n.size() == 0) begin
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL mon_n unexpected word: got %0h expected none", bus_n.dout);
      end else begin
        e = q_n.pop_front();
        check("mon_n dout", 32'(bus_n.dout), 32'(e.data));
        check("mon_n parity_err", 32'(bus_n.parity_err), 32'(e.perr));
        check("mon_n overrun", 32'(bus_n.overrun), 32'(e.ovr));
      end
    end
    pv_n <= bus_n.dout_valid;
    pd_n <= bus_n.dout;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] c3;
    logic [7:0] d80;
    exp_t       e;
    rst            = 1'b0;
    bus_p.din      = 1'b1;
    bus_p.dout_ack = 1'b0;
    bus_n.din      = 1'b1;
    bus_n.dout_ack = 1'b0;
    repeat (2) tick();

    check("reset dout", 32'(bus_p.dout), 32'h0);
    check("reset dout_valid", 32'(bus_p.dout_valid), 32'h0);
    check("reset status", 32'({bus_p.parity_err, bus_p.frame_err, bus_p.overrun, bus_p.busy}), 32'h0);
    check("reset busy n", 32'(bus_n.busy), 32'h0);
    rst = 1'b1;
    tick();

    // 1: good frame 0xA5, even parity bit 0
    frame_p(8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
    check("t1 valid", 32'(bus_p.dout_valid), 32'h1);
    check("t1 busy after stop", 32'(bus_p.busy), 32'h0);
    ack_p();
    check("t1 valid after ack", 32'(bus_p.dout_valid), 32'h0);

    // 2: same data, wrong parity bit
    frame_p(8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
    ack_p();
    check("t2 valid after ack", 32'(bus_p.dout_valid), 32'h0);

    // 3: 0x5A with a low stop bit, then line held low
    bit_p(1'b0);
    check("t3 busy in data", 32'(bus_p.busy), 32'h1);
    bit_p(1'b0); bit_p(1'b1); bit_p(1'b0); bit_p(1'b1);
    bit_p(1'b1); bit_p(1'b0); bit_p(1'b1); bit_p(1'b0);
    bit_p(1'b0);
    bit_p(1'b0);
    check("t3 frame_err pulse", 32'(bus_p.frame_err), 32'h1);
    check("t3 valid untouched", 32'(bus_p.dout_valid), 32'h0);
    check("t3 dout untouched", 32'(bus_p.dout), 32'hA5);
    bit_p(1'b0);
    check("t3 frame_err one cycle", 32'(bus_p.frame_err), 32'h0);
    bit_p(1'b0);
    bit_p(1'b0);
    check("t3 busy in break", 32'(bus_p.busy), 32'h1);
    bit_p(1'b1);
    check("t3 idle after break", 32'(bus_p.busy), 32'h0);
    bit_p(1'b1);
    check("t3 no false start", 32'(bus_p.busy), 32'h0);

    // 4: back-to-back frames without ack, then with ack on the second stop
    frame_p(8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
    frame_p(8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
    check("t4 overrun set", 32'(bus_p.overrun), 32'h1);
    ack_p();
    check("t4 overrun cleared", 32'(bus_p.overrun), 32'h0);
    check("t4 valid cleared", 32'(bus_p.dout_valid), 32'h0);
    frame_p(8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
    frame_p(8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    check("t4b valid stays", 32'(bus_p.dout_valid), 32'h1);
    check("t4b overrun clear", 32'(bus_p.overrun), 32'h0);
    ack_p();

    // 5: valid word pending, reset in the middle of 0xC3
    frame_p(8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
    c3 = 8'hC3;
    bit_p(1'b0);
    for (int i = 0; i < 4; i++) bit_p(c3[i]);
    #2;
    rst = 1'b0;
    #1;
    check("t5 reset dout", 32'(bus_p.dout), 32'h0);
    check("t5 reset valid", 32'(bus_p.dout_valid), 32'h0);
    check("t5 reset busy", 32'(bus_p.busy), 32'h0);
    tick();
    rst = 1'b1;
    bit_p(1'b1);
    check("t5 no pulse after release", 32'({bus_p.dout_valid, bus_p.frame_err}), 32'h0);
    frame_p(8'h01, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    ack_p();

    // 6: parity-less instance, 0x80 in 10 cycles
    e.data = 8'h80;
    e.perr = 1'b0;
    e.ovr  = 1'b0;
    q_n.push_back(e);
    d80 = 8'h80;
    bus_n.din = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      bus_n.din = d80[i];
      tick();
    end
    check("t6 not before stop", 32'(bus_n.dout_valid), 32'h0);
    bus_n.din = 1'b1;
    tick();
    check("t6 valid", 32'(bus_n.dout_valid), 32'h1);
    check("t6 busy", 32'(bus_n.busy), 32'h0);
    tick();

    check("queue p drained", 32'(q_p.size()), 32'h0);
    check("queue n drained", 32'(q_n.size()), 32'h0);
    check("frame_err pulse count", 32'(fe_cnt), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
